// File: rtl/sram_ctrl_pkg.sv
// Shared types and counter widths for the asynchronous SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Beat index must also hold the one-past-last value that ends an access.
  localparam int unsigned BEAT_W = 4;
  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/sram_ctrl_dq_io.sv
// Tristate driver for the SRAM data bus and read-path capture into bus-width read data.
module sram_ctrl_dq_io
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_DW = 16,
  parameter int unsigned BUS_DW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               drive_en,
  input  logic [SRAM_DW-1:0] wr_data,
  input  logic               capture,
  input  logic [BEAT_W-1:0]  beat,
  output logic [BUS_DW-1:0]  rdata,
  inout  wire  [SRAM_DW-1:0] sram_dq
);

  logic [BUS_DW-1:0] rdata_d;
  logic [BUS_DW-1:0] rdata_q;

  assign sram_dq = drive_en ? wr_data : 'z;

  always_comb begin
    rdata_d = rdata_q;
    if (capture) begin
      rdata_d[int'(beat)*SRAM_DW +: SRAM_DW] = sram_dq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// Bus-to-asynchronous-SRAM controller: splits each bus access into BUS_DW/SRAM_DW timed beats.
// Optional macro SRAM_CTRL_BEAT_SKIP_EN: write beats with an all-zero byte-enable slice are skipped.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_AW     = 19,
  parameter int unsigned SRAM_DW     = 16,
  parameter int unsigned BUS_DW      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_read,
  input  logic                 bus_write,
  input  logic [31:0]          bus_address,
  input  logic [BUS_DW-1:0]    bus_writedata,
  input  logic [BUS_DW/8-1:0]  bus_byteenable,
  output logic [BUS_DW-1:0]    bus_readdata,
  output logic                 bus_ready,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [SRAM_DW/8-1:0] sram_be_n,
  output logic [SRAM_AW-1:0]   sram_addr,
  inout  wire  [SRAM_DW-1:0]   sram_dq
);

  localparam int unsigned N       = BUS_DW / SRAM_DW;
  localparam int unsigned SBE     = SRAM_DW / 8;
  localparam int unsigned BBE     = BUS_DW / 8;
  localparam int unsigned BYTE_SH = $clog2(BBE);
  localparam int unsigned BEAT_SH = $clog2(N);

  localparam logic [BEAT_W-1:0] BEAT_END  = BEAT_W'(N);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  state_e              state_d, state_q;
  logic [BEAT_W-1:0]   beat_d, beat_q;
  logic [WAIT_W-1:0]   wait_d, wait_q;
  logic [SRAM_AW-1:0]  addr_d, addr_q;
  logic [BUS_DW-1:0]   wdata_d, wdata_q;
  logic [BBE-1:0]      be_d, be_q;
  logic                wr_d, wr_q;

  logic [31:0]         word_base;
  logic                unused_word_base;
  logic [BEAT_W-1:0]   first_beat;
  logic [BEAT_W-1:0]   next_beat;

  logic                dq_drive;
  logic                dq_capture;
  logic [SRAM_DW-1:0]  dq_wr_slice;
  logic                beat_last_cycle;

  // Byte address to the SRAM word of beat 0; upper bits fall off so large addresses wrap.
  assign word_base        = (bus_address >> BYTE_SH) << BEAT_SH;
  assign unused_word_base = ^word_base;

`ifdef SRAM_CTRL_BEAT_SKIP_EN
  function automatic logic [BEAT_W-1:0] seek_beat(input logic [BBE-1:0]    be,
                                                  input logic [BEAT_W-1:0] start);
    logic [BEAT_W-1:0] pick;
    int unsigned       b;
    pick = BEAT_END;
    for (int unsigned i = 0; i < N; i++) begin
      b = N - 1 - i;
      if (BEAT_W'(b) >= start && (|be[b*SBE +: SBE])) begin
        pick = BEAT_W'(b);
      end
    end
    return pick;
  endfunction

  always_comb begin
    first_beat = bus_write ? seek_beat(bus_byteenable, '0) : '0;
    next_beat  = wr_q ? seek_beat(be_q, beat_q + BEAT_W'(1)) : beat_q + BEAT_W'(1);
  end
`else
  always_comb begin
    first_beat = '0;
    next_beat  = beat_q + BEAT_W'(1);
  end
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_read || bus_write) begin
          wr_d    = bus_write;
          addr_d  = word_base[SRAM_AW-1:0];
          wdata_d = bus_writedata;
          be_d    = bus_byteenable;
          beat_d  = first_beat;
          wait_d  = '0;
          state_d = (first_beat >= BEAT_END) ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          wait_d = '0;
          beat_d = next_beat;
          if (next_beat >= BEAT_END) begin
            state_d = ST_DONE;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
    end
  end

  // Strobes decode straight from registered state so reset forces them inactive at the next edge.
  always_comb begin
    sram_ce_n       = 1'b1;
    sram_oe_n       = 1'b1;
    sram_we_n       = 1'b1;
    sram_be_n       = '1;
    sram_addr       = '0;
    dq_drive        = 1'b0;
    dq_capture      = 1'b0;
    dq_wr_slice     = '0;
    beat_last_cycle = (wait_q == WAIT_LAST);
    if (state_q == ST_ACCESS) begin
      sram_ce_n = 1'b0;
      sram_addr = addr_q + SRAM_AW'(beat_q);
      if (wr_q) begin
        sram_be_n   = ~be_q[int'(beat_q)*SBE +: SBE];
        sram_we_n   = beat_last_cycle;
        dq_drive    = 1'b1;
        dq_wr_slice = wdata_q[int'(beat_q)*SRAM_DW +: SRAM_DW];
      end else begin
        sram_oe_n  = 1'b0;
        sram_be_n  = '0;
        dq_capture = beat_last_cycle;
      end
    end
  end

  assign bus_ready = (state_q == ST_DONE);

  sram_ctrl_dq_io #(
    .SRAM_DW (SRAM_DW),
    .BUS_DW  (BUS_DW)
  ) u_dq (
    .clk      (clk),
    .rst      (rst),
    .drive_en (dq_drive),
    .wr_data  (dq_wr_slice),
    .capture  (dq_capture),
    .beat     (beat_q),
    .rdata    (bus_readdata),
    .sram_dq  (sram_dq)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed scoreboard bench for sram_ctrl: a 16-bit/1-wait instance and an 8-bit/3-wait instance.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_mem;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic [31:0] rdata_a, rdata_b;
  logic        rdy_a, rdy_b;
  logic        ce_a, oe_a, we_a, ce_b, oe_b, we_b;
  logic [1:0]  ben_a;
  logic [0:0]  ben_b;
  logic [18:0] sa_a, sa_b;
  wire  [15:0] dq_a;
  wire  [7:0]  dq_b;

  logic [15:0] mem_a [0:255];
  logic [7:0]  mem_b [0:255];

  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] trace_addr[$];
  logic        trace_we[$];
  logic        trace_oe[$];
  logic [1:0]  trace_be[$];
  int          we_low_cnt;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sram_ctrl #(
    .SRAM_AW     (19),
    .SRAM_DW     (16),
    .BUS_DW      (32),
    .WAIT_CYCLES (1)
  ) dut_a (
    .clk            (clk),
    .rst            (rst),
    .bus_read       (rd_a),
    .bus_write      (wr_a),
    .bus_address    (addr),
    .bus_writedata  (wdata),
    .bus_byteenable (be),
    .bus_readdata   (rdata_a),
    .bus_ready      (rdy_a),
    .sram_ce_n      (ce_a),
    .sram_oe_n      (oe_a),
    .sram_we_n      (we_a),
    .sram_be_n      (ben_a),
    .sram_addr      (sa_a),
    .sram_dq        (dq_a)
  );

  sram_ctrl #(
    .SRAM_AW     (19),
    .SRAM_DW     (8),
    .BUS_DW      (32),
    .WAIT_CYCLES (3)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .bus_read       (rd_b),
    .bus_write      (wr_b),
    .bus_address    (addr),
    .bus_writedata  (wdata),
    .bus_byteenable (be),
    .bus_readdata   (rdata_b),
    .bus_ready      (rdy_b),
    .sram_ce_n      (ce_b),
    .sram_oe_n      (oe_b),
    .sram_we_n      (we_b),
    .sram_be_n      (ben_b),
    .sram_addr      (sa_b),
    .sram_dq        (dq_b)
  );

  // SRAM models: drive data while read-enabled, store enabled bytes while write-enabled.
  assign dq_a = (!ce_a && !oe_a && we_a) ? mem_a[sa_a[7:0]] : 'z;
  assign dq_b = (!ce_b && !oe_b && we_b) ? mem_b[sa_b[7:0]] : 'z;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 16'h1000 + 16'(i);
        mem_b[i] <= 8'(i) ^ 8'h5A;
      end
    end else begin
      if (!ce_a && !we_a) begin
        if (!ben_a[0]) mem_a[sa_a[7:0]][7:0]  <= dq_a[7:0];
        if (!ben_a[1]) mem_a[sa_a[7:0]][15:8] <= dq_a[15:8];
      end
      if (!ce_b && !we_b && !ben_b[0]) mem_b[sa_b[7:0]] <= dq_b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, hold it until ready (bounded), then compare against the scoreboard.
  task automatic xact(input int sel, input string tag, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                      input int exp_cyc, input logic [31:0] exp_rd);
    int          cyc;
    logic [31:0] rdv;
    exp_t        e;
    sb.push_back('{tag: tag, cyc: exp_cyc, data: exp_rd});
    trace_addr.delete(); trace_we.delete(); trace_oe.delete(); trace_be.delete();
    we_low_cnt = 0;
    cyc = -1;
    rdv = '0;
    @(negedge clk);
    addr = a; wdata = wd; be = b;
    if (sel == 0) begin rd_a = rd; wr_a = wr; end
    else          begin rd_b = rd; wr_b = wr; end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (sel == 0) begin
        trace_addr.push_back(32'(sa_a)); trace_we.push_back(we_a);
        trace_oe.push_back(oe_a);        trace_be.push_back(ben_a);
        if (!we_a) we_low_cnt++;
        if (rdy_a) begin cyc = c; rdv = rdata_a; break; end
      end else begin
        trace_addr.push_back(32'(sa_b)); trace_we.push_back(we_b);
        trace_oe.push_back(oe_b);        trace_be.push_back({1'b0, ben_b});
        if (!we_b) we_low_cnt++;
        if (rdy_b) begin cyc = c; rdv = rdata_b; break; end
      end
    end
    rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_ready_cycle"}, 64'(cyc), 64'(e.cyc));
    chk({e.tag, "_readdata"}, 64'(rdv), 64'(e.data));
    @(negedge clk);
    chk({e.tag, "_ready_one_cycle"}, 64'(sel == 0 ? rdy_a : rdy_b), 64'(0));
  endtask

  initial begin
    bit saw_ready;
    rst = 1'b1; init_mem = 1'b1;
    rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 64'({ce_a, oe_a, we_a, ben_a}), 64'(5'b11111));
    chk("rst_addr_ready", 64'({sa_a, rdy_a}), 64'(0));
    chk("rst_readdata", 64'(rdata_a), 64'(0));
    chk("rst_dq_hiz", 64'(dut_a.u_dq.drive_en), 64'(0));
    init_mem = 1'b0; rst = 1'b0;
    @(negedge clk);

    xact(0, "wr_full", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 5, 32'h0);
    chk("wr_full_mem80", 64'(mem_a[8'h80]), 64'(16'hBEEF));
    chk("wr_full_mem81", 64'(mem_a[8'h81]), 64'(16'hDEAD));
    chk("wr_full_addr_order", 64'({trace_addr[0], trace_addr[2]}), {32'h80, 32'h81});
    chk("wr_full_we_shape", 64'({trace_we[0], trace_we[1], trace_we[2], trace_we[3]}), 64'(4'b0101));

    xact(0, "rd_full", 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 5, 32'hDEADBEEF);
    chk("rd_full_we_never_low", 64'(we_low_cnt), 64'(0));
    chk("rd_full_oe_be", 64'({trace_oe[0], trace_be[0]}), 64'(3'b000));

`ifdef SRAM_CTRL_BEAT_SKIP_EN
    xact(0, "wr_half", 1'b0, 1'b1, 32'h100, 32'h12345678, 4'h3, 3, 32'hDEADBEEF);
`else
    xact(0, "wr_half", 1'b0, 1'b1, 32'h100, 32'h12345678, 4'h3, 5, 32'hDEADBEEF);
    chk("wr_half_beat1_be_n", 64'(trace_be[2]), 64'(2'b11));
    chk("wr_half_we_pulses", 64'(we_low_cnt), 64'(2));
`endif
    chk("wr_half_mem80", 64'(mem_a[8'h80]), 64'(16'h5678));
    chk("wr_half_mem81", 64'(mem_a[8'h81]), 64'(16'hDEAD));

`ifdef SRAM_CTRL_BEAT_SKIP_EN
    xact(0, "wr_none", 1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 1, 32'hDEADBEEF);
`else
    xact(0, "wr_none", 1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 5, 32'hDEADBEEF);
`endif
    chk("wr_none_mem", 64'({mem_a[8'h81], mem_a[8'h80]}), 64'(32'hDEAD5678));

    xact(0, "rd_and_wr", 1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 5, 32'hDEADBEEF);
    chk("rd_and_wr_mem", 64'({mem_a[8'h81], mem_a[8'h80]}), 64'(32'hCAFEF00D));
    chk("rd_and_wr_oe_high", 64'(trace_oe[0]), 64'(1));
    xact(0, "rd_back", 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 5, 32'hCAFEF00D);

    xact(0, "rd_wrap", 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 5, 32'h10FF10FE);
    chk("rd_wrap_addr", 64'({trace_addr[0], trace_addr[2]}), {32'h7FFFE, 32'h7FFFF});

    @(negedge clk);
    addr = 32'h100; wdata = 32'h11112222; be = 4'hF; wr_a = 1'b1;
    @(negedge clk);
    chk("rst_mid_active", 64'({ce_a, dut_a.u_dq.drive_en}), 64'(2'b01));
    rst = 1'b1; wr_a = 1'b0;
    @(negedge clk);
    chk("rst_mid_strobes", 64'({ce_a, oe_a, we_a, ben_a}), 64'(5'b11111));
    chk("rst_mid_dq_hiz", 64'(dut_a.u_dq.drive_en), 64'(0));
    chk("rst_mid_addr_rdata", 64'({sa_a, rdata_a}), 64'(0));
    rst = 1'b0;
    saw_ready = rdy_a;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_ready |= rdy_a;
    end
    chk("rst_mid_no_ready", 64'(saw_ready), 64'(0));

    xact(1, "b_rd", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 17, 32'h19181B1A);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b_rd_addr_beat%0d", k),
          64'({trace_addr[4*k], trace_addr[4*k+3]}), {32'h40 + 32'(k), 32'h40 + 32'(k)});
    end
    chk("b_rd_we_never_low", 64'(we_low_cnt), 64'(0));

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
